// File: rtl/dbus_uart_pkg.sv
// Shared definitions for the data-bus UART transmitter.
//   REG_*  : word offsets decoded from addr[1:0]
//   ST_*   : bit positions inside the STATUS register
//   tx_state_e : serialiser FSM states
package dbus_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port.
//   clk, resetn     : clock, async active-low reset (pointers/count only)
//   push, din       : write request; ignored while full
//   pop, dout       : read request; dout shows the head entry; ignored while empty
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // Fullness is judged on the pre-edge count, so a same-cycle pop never frees a slot.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus (data-RAM style access).
//   clk, resetn : clock, async active-low reset
//   en          : block selected this cycle
//   wen[3:0]    : byte write enables
//   addr        : word address, only addr[1:0] decoded
//   wdata       : write data
//   rdata       : read data, registered, updated only on en cycles
//   uart_tx     : registered serial output, idles high
//   tx_busy     : FSM active or bytes still queued
module dbus_uart_tx
  import dbus_uart_pkg::*;
#(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 22
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              uart_tx,
  output logic              tx_busy
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_DIV);

  tx_state_e   state_q, state_d;
  logic [15:0] div_reg_q;          // programmed divisor
  logic [15:0] div_q, div_d;       // divisor frozen for the current frame
  logic [15:0] cnt_q, cnt_d;       // baud counter, counts down to 0
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shr_q, shr_d;
  logic        tx_q, tx_d;
  logic        ovf_q;
  logic [31:0] rdata_q;

  logic          push, pop, load, ovf_clr, div_we;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status, rd_mux;
  logic          unused_bits;

  assign unused_bits = ^{addr[ADDR_W-1:2], wen[3:2], wdata[31:16]};

  assign push    = en & wen[0] & (addr[1:0] == REG_TXDATA);
  assign ovf_clr = en & wen[0] & wdata[ST_OVF] & (addr[1:0] == REG_STATUS);
  assign div_we  = en & wen[0] & wen[1] & (addr[1:0] == REG_DIV);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (wdata[7:0]),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign tx_busy = (state_q != S_IDLE) | ~fifo_empty;
  assign uart_tx = tx_q;
  assign rdata   = rdata_q;

  always_comb begin
    status           = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = tx_busy;
    status[ST_OVF]   = ovf_q;
    case (addr[1:0])
      REG_TXDATA: rd_mux = 32'(fifo_count);
      REG_STATUS: rd_mux = status;
      REG_DIV:    rd_mux = {16'b0, div_reg_q};
      default:    rd_mux = '0;
    endcase
  end

  // tx_d is the line level for the coming bit, so uart_tx changes exactly at
  // the bit boundary edge and comes straight from a flop.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shr_d   = shr_q;
    tx_d    = tx_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: load = ~fifo_empty;
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = div_q - 16'd1;
          bit_d   = 3'd0;
          tx_d    = shr_q[0];
        end else cnt_d = cnt_q - 16'd1;
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = div_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            shr_d = {1'b0, shr_q[7:1]};
            tx_d  = shr_q[1];
          end
        end else cnt_d = cnt_q - 16'd1;
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          // Back-to-back frames: go straight to START with no idle bit.
          if (!fifo_empty) load = 1'b1;
          else state_d = S_IDLE;
        end else cnt_d = cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d = S_START;
      div_d   = div_reg_q;
      cnt_d   = div_reg_q - 16'd1;
      shr_d   = fifo_dout;
      tx_d    = 1'b0;
    end
  end

  assign pop = load;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      div_reg_q <= DIV_RST;
      div_q     <= DIV_RST;
      cnt_q     <= '0;
      bit_q     <= '0;
      shr_q     <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shr_q   <= shr_d;
      tx_q    <= tx_d;
      if (en) rdata_q <= rd_mux;
      if (push && fifo_full) ovf_q <= 1'b1;
      else if (ovf_clr)      ovf_q <= 1'b0;
      if (div_we) div_reg_q <= (wdata[15:0] == '0) ? 16'd1 : wdata[15:0];
    end
  end

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Self-checking bench for dbus_uart_tx (CLK_DIV=4, FIFO_DEPTH=8).
// A timeline reference model (byte queue + frame start time) predicts uart_tx,
// tx_busy and rdata every cycle; directed scenarios add explicit checks.
module tb_dbus_uart_tx;
  localparam int DIVR  = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = '0;
  logic [21:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        uart_tx, tx_busy;

  int n_chk = 0;
  int n_err = 0;

  dbus_uart_tx #(.CLK_DIV(DIVR), .FIFO_DEPTH(DEPTH), .ADDR_W(22)) dut (
    .clk(clk), .resetn(resetn), .en(en), .wen(wen), .addr(addr),
    .wdata(wdata), .rdata(rdata), .uart_tx(uart_tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  q[$];
  int          kcyc = 0;
  bit          m_act = 0;
  int          m_start = 0;
  int          m_fdiv = DIVR;
  logic [7:0]  m_byte = '0;
  bit          m_ovf = 0;
  int          m_div = DIVR;
  logic [31:0] m_rd = '0;

  always @(posedge clk or negedge resetn) begin
    bit full_pre, busy_pre;
    if (!resetn) begin
      q.delete(); kcyc = 0; m_act = 0; m_ovf = 0; m_div = DIVR; m_rd = '0;
    end else begin
      kcyc++;
      full_pre = (q.size() == DEPTH);
      busy_pre = m_act || (q.size() != 0);
      if (en) begin
        case (addr[1:0])
          2'd0: m_rd = 32'(q.size());
          2'd1: m_rd = {28'b0, m_ovf, busy_pre, (q.size() == 0), full_pre};
          2'd2: m_rd = 32'(m_div);
          default: m_rd = '0;
        endcase
      end
      // a frame occupies exactly 10*div edges starting at its pop edge
      if (m_act && (kcyc - m_start >= 10 * m_fdiv)) m_act = 0;
      if (!m_act && q.size() != 0) begin
        m_byte = q.pop_front(); m_act = 1; m_start = kcyc; m_fdiv = m_div;
      end
      if (en && wen[0] && addr[1:0] == 2'd0) begin
        if (full_pre) m_ovf = 1;
        else q.push_back(wdata[7:0]);
      end
      if (en && wen[0] && wdata[3] && addr[1:0] == 2'd1) m_ovf = 0;
      if (en && wen[0] && wen[1] && addr[1:0] == 2'd2)
        m_div = (wdata[15:0] == 0) ? 1 : int'(wdata[15:0]);
    end
  end

  function automatic logic exp_tx();
    int idx;
    if (!m_act) return 1'b1;
    idx = (kcyc - m_start) / m_fdiv;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (resetn) begin
      chk("uart_tx", 32'(uart_tx), 32'(exp_tx()));
      chk("tx_busy", 32'(tx_busy), 32'(m_act || q.size() != 0));
      chk("rdata",   rdata, m_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic e, input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk);
    en = e; addr = {20'b0, a}; wen = w; wdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 2'd0, 4'd0, 32'd0);
  endtask

  // Counts consecutive busy samples, starting at the next falling edge.
  task automatic run_until_idle(output int n);
    n = 0;
    @(negedge clk);
    en = 1'b0; wen = '0;
    while (tx_busy === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    #23 resetn = 1'b1;

    // reset / STATUS read
    cyc(1, 2'd1, 4'd0, 0); idle(1);
    chk("status_rst", rdata, 32'h2);
    chk("tx_idle", 32'(uart_tx), 32'h1);

    // single byte: one sample queued in FIFO + 40-cycle frame
    cyc(1, 2'd0, 4'b0001, 32'hA5);
    run_until_idle(n);
    chk("a5_busy_len", 32'(n), 32'd41);

    // overflow: 10 pushes, 9 accepted
    for (int i = 0; i < 10; i++) cyc(1, 2'd0, 4'b0001, 32'(8'h10 + i));
    cyc(1, 2'd1, 4'd0, 0); idle(1);
    chk("status_ovf", rdata, 32'h0D);
    cyc(1, 2'd0, 4'd0, 0); idle(1);
    chk("count_full", rdata, 32'd8);
    cyc(1, 2'd1, 4'b0001, 32'h8);
    cyc(1, 2'd1, 4'd0, 0); idle(1);
    chk("status_w1c", rdata, 32'h05);
    run_until_idle(n);
    chk("drain_done", 32'(n < 5000), 32'd1);

    // back-to-back frames: 80 contiguous busy cycles from first start bit
    cyc(1, 2'd0, 4'b0001, 32'h55);
    cyc(1, 2'd0, 4'b0001, 32'h0F);
    run_until_idle(n);
    chk("b2b_len", 32'(n), 32'd80);
    cyc(1, 2'd0, 4'b0000, 32'h77);
    cyc(1, 2'd1, 4'd0, 0); idle(1);
    chk("no_push_wen0", rdata, 32'h2);

    // DIV change mid-frame: push at edge N, DIV=2 at N+10, push at N+11;
    // frames run N+1..N+40 (div 4) and N+41..N+60 (div 2) -> 50 busy samples
    cyc(1, 2'd0, 4'b0001, 32'hC3);
    idle(9);
    cyc(1, 2'd2, 4'b0011, 32'd2);
    cyc(1, 2'd0, 4'b0001, 32'h3A);
    run_until_idle(n);
    chk("div_midframe", 32'(n), 32'd50);
    cyc(1, 2'd2, 4'b0011, 32'd0);
    cyc(1, 2'd2, 4'd0, 0); idle(1);
    chk("div_zero", rdata, 32'h1);
    cyc(1, 2'd3, 4'b1111, 32'hFFFF_FFFF);
    cyc(1, 2'd3, 4'd0, 0); idle(1);
    chk("rsvd_zero", rdata, 32'h0);
    cyc(1, 2'd2, 4'b0011, 32'd4);

    // randomized bus traffic
    for (int i = 0; i < 1500; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd2) d = 32'($urandom_range(0, 5));
      cyc(1'($urandom_range(0, 1)), a, 4'($urandom), d);
    end
    run_until_idle(n);
    chk("rand_drain", 32'(n < 5000), 32'd1);

    // reset mid-DATA: DIV=3, push at edge N, start bit N+1..N+3, data from N+4
    cyc(1, 2'd2, 4'b0011, 32'd3);
    cyc(1, 2'd0, 4'b0001, 32'h3C);
    idle(7);
    cyc(1, 2'd2, 4'd0, 0);
    @(negedge clk);
    en = 1'b0;
    chk("pre_rst_div", rdata, 32'd3);
    #1 resetn = 1'b0;
    #1;
    chk("rst_tx", 32'(uart_tx), 32'h1);
    chk("rst_busy", 32'(tx_busy), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    #1 resetn = 1'b1;
    cyc(1, 2'd2, 4'd0, 0); idle(1);
    chk("rst_div", rdata, 32'd4);
    cyc(1, 2'd1, 4'd0, 0); idle(1);
    chk("rst_status", rdata, 32'h2);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
